// File: rtl/wifi_ahb_addr_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wifi_dec_pkg
// Purpose  : Shared types and helpers for the WiFi AHB address decoder:
//            data-phase state encoding, HTRANS encodings, window classes
//            and the transfer alignment check.
// Revision : 1.0 - initial release
// ============================================================================
package wifi_dec_pkg;

    // Data-phase state of the slave
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_WAIT = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } dec_state_t;

    // AHB-Lite HTRANS encodings
    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    // Which local window an address phase falls into
    typedef enum logic [1:0] {
        WIN_REG = 2'd0,
        WIN_MEM = 2'd1,
        WIN_ERR = 2'd2
    } win_cls_t;

    // Byte, halfword and word accesses must be naturally aligned; wider
    // sizes are not supported by this slave at all.
    function automatic logic is_aligned(input logic [1:0] addr_lsb,
                                        input logic [2:0] size);
        logic ok;
        ok = 1'b0;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = ~addr_lsb[0];
            3'd2:    ok = (addr_lsb == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wifi_ahb_addr_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : wifi_ahb_addr_decoder_if
// Purpose  : AHB-Lite slave-slot signals between the interconnect and the
//            WiFi PHY address decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface wifi_ahb_addr_decoder_if #(
    parameter int ADDR_AHB = 12
);
    logic                HSEL;
    logic [ADDR_AHB-1:0] HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic                HREADY;
    logic                HREADYOUT;
    logic                HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
        input  HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
        output HREADYOUT, HRESP
    );
endinterface
`default_nettype wire

// File: rtl/wifi_ahb_addr_decoder_window.sv
`default_nettype none
// ============================================================================
// Module   : wifi_dec_window
// Purpose  : Combinational address-phase classifier. Splits HADDR into the
//            register window, the memory window or an error, and produces
//            the local register index and memory byte offset.
// Revision : 1.0 - initial release
// ============================================================================
module wifi_dec_window
    import wifi_dec_pkg::*;
#(
    parameter int ADDR_AHB  = 12,
    parameter int ADDR_SLIC = 10,
    parameter int NUM_REGS  = 4,
    parameter int MEM_BASE  = 'h10,
    parameter int MEM_BYTES = 1024
) (
    input  wire logic [ADDR_AHB-1:0]         i_haddr,
    input  wire logic [2:0]                  i_hsize,
    output win_cls_t                         o_cls,
    output logic [$clog2(NUM_REGS)-1:0]      o_reg_idx,
    output logic [ADDR_SLIC-1:0]             o_mem_off
);

    localparam int c_REG_W = $clog2(NUM_REGS);

    // One extra bit so the window end addresses never wrap
    localparam logic [ADDR_AHB:0] c_REG_END = (ADDR_AHB+1)'(4 * NUM_REGS);
    localparam logic [ADDR_AHB:0] c_MEM_LO  = (ADDR_AHB+1)'(MEM_BASE);
    localparam logic [ADDR_AHB:0] c_MEM_HI  = (ADDR_AHB+1)'(MEM_BASE + MEM_BYTES);

    logic [ADDR_AHB:0] w_addr;
    assign w_addr = {1'b0, i_haddr};

    // Misalignment overrides any window hit; gaps fall through to ERR
    always_comb begin
        o_cls = WIN_ERR;
        if (!is_aligned(i_haddr[1:0], i_hsize)) begin
            o_cls = WIN_ERR;
        end else if (w_addr < c_REG_END) begin
            o_cls = WIN_REG;
        end else if ((w_addr >= c_MEM_LO) && (w_addr < c_MEM_HI)) begin
            o_cls = WIN_MEM;
        end
    end

    assign o_reg_idx = i_haddr[2 +: c_REG_W];
    assign o_mem_off = ADDR_SLIC'(i_haddr - ADDR_AHB'(MEM_BASE));

endmodule
`default_nettype wire

// File: rtl/wifi_ahb_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : wifi_ahb_addr_decoder
// Purpose  : AHB-Lite slave front end for the WiFi PHY. Registers the
//            address phase, issues single-cycle register/memory strobes in
//            the data phase, inserts memory wait states and answers
//            out-of-range or misaligned accesses with a two-cycle ERROR.
// Options  : WIFI_DEC_STATS_EN - adds stat_clr input and a saturating
//            8-bit err_count output.
// Revision : 1.0 - initial release
// ============================================================================
module wifi_ahb_addr_decoder
    import wifi_dec_pkg::*;
#(
    parameter int ADDR_AHB  = 12,
    parameter int ADDR_SLIC = 10,
    parameter int NUM_REGS  = 4,
    parameter int MEM_BASE  = 'h10,
    parameter int MEM_BYTES = 1024,
    parameter int MEM_WAIT  = 0
) (
    input  wire logic                         HCLK,
    input  wire logic                         HRESETn,
    wifi_ahb_addr_decoder_if.slave            ahb,
    output logic                              wren_reg,
    output logic                              rden_reg,
    output logic [$clog2(NUM_REGS)-1:0]       addr_reg,
    output logic                              wren_mem,
    output logic                              rden_mem,
    output logic [ADDR_SLIC-1:0]              addr_mem
`ifdef WIFI_DEC_STATS_EN
    ,
    input  wire logic                         stat_clr,
    output logic [7:0]                        err_count
`endif
);

    localparam logic       c_MEM_STALL = (MEM_WAIT > 0);
    localparam logic [3:0] c_WAIT_LOAD = 4'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

    dec_state_t                    r_state;
    dec_state_t                    w_state_nxt;
    win_cls_t                      w_cls;
    logic [$clog2(NUM_REGS)-1:0]   w_reg_idx;
    logic [ADDR_SLIC-1:0]          w_mem_off;
    logic [$clog2(NUM_REGS)-1:0]   r_addr_reg;
    logic [ADDR_SLIC-1:0]          r_addr_mem;
    logic                          r_write;
    logic                          r_is_mem;
    logic [3:0]                    r_wait_cnt;
    logic                          w_accept;
    logic                          w_take;
    logic                          w_start;
    logic                          w_strobe;
    logic                          w_hreadyout;
    logic                          w_hresp;
    logic                          w_data_phase;

    wifi_dec_window #(
        .ADDR_AHB  (ADDR_AHB),
        .ADDR_SLIC (ADDR_SLIC),
        .NUM_REGS  (NUM_REGS),
        .MEM_BASE  (MEM_BASE),
        .MEM_BYTES (MEM_BYTES)
    ) u_window (
        .i_haddr   (ahb.HADDR),
        .i_hsize   (ahb.HSIZE),
        .o_cls     (w_cls),
        .o_reg_idx (w_reg_idx),
        .o_mem_off (w_mem_off)
    );

    // Only NONSEQ/SEQ with the bus ready start a transfer
    assign w_accept = ahb.HSEL & ahb.HREADY &
                      ((ahb.HTRANS == c_HTRANS_NONSEQ) || (ahb.HTRANS == c_HTRANS_SEQ));
    assign w_start  = w_take & w_accept;

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and bus response; w_take marks the cycle the current
    // data phase completes, so a new address phase can be accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_hreadyout = 1'b1;
        w_hresp     = 1'b0;
        w_strobe    = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_take = 1'b1;
            end
            ST_DATA: begin
                w_strobe = 1'b1;
                if (r_is_mem && c_MEM_STALL) begin
                    w_hreadyout = 1'b0;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_take = 1'b1;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt != 4'd0) begin
                    w_hreadyout = 1'b0;
                end else begin
                    w_take = 1'b1;
                end
            end
            ST_ERR1: begin
                w_hresp     = 1'b1;
                w_hreadyout = 1'b0;
                w_state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                w_hresp = 1'b1;
                w_take  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_take) begin
            if (w_accept) begin
                w_state_nxt = (w_cls == WIN_ERR) ? ST_ERR1 : ST_DATA;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Capture direction and local addresses of an accepted address phase;
    // the address of the unused window is stored as zero.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_write    <= 1'b0;
            r_is_mem   <= 1'b0;
            r_addr_reg <= '0;
            r_addr_mem <= '0;
        end else if (w_start) begin
            r_write    <= ahb.HWRITE;
            r_is_mem   <= (w_cls == WIN_MEM);
            r_addr_reg <= (w_cls == WIN_REG) ? w_reg_idx : '0;
            r_addr_mem <= (w_cls == WIN_MEM) ? w_mem_off : '0;
        end
    end

    // Memory wait-state counter, loaded when the data phase stalls
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wait_cnt <= 4'd0;
        end else if ((r_state == ST_DATA) && (w_state_nxt == ST_WAIT)) begin
            r_wait_cnt <= c_WAIT_LOAD;
        end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    assign w_data_phase  = (r_state == ST_DATA) || (r_state == ST_WAIT);

    assign ahb.HREADYOUT = w_hreadyout;
    assign ahb.HRESP     = w_hresp;

    assign wren_reg = w_strobe &  r_write & ~r_is_mem;
    assign rden_reg = w_strobe & ~r_write & ~r_is_mem;
    assign wren_mem = w_strobe &  r_write &  r_is_mem;
    assign rden_mem = w_strobe & ~r_write &  r_is_mem;
    assign addr_reg = w_data_phase ? r_addr_reg : '0;
    assign addr_mem = w_data_phase ? r_addr_mem : '0;

`ifdef WIFI_DEC_STATS_EN
    logic [7:0] r_err_count;

    // Count ERROR transfers, saturating; a clear beats a same-cycle increment
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_count <= 8'd0;
        end else if (stat_clr) begin
            r_err_count <= 8'd0;
        end else if (w_start && (w_cls == WIN_ERR) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wifi_ahb_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_wifi_ahb_addr_decoder
// Purpose  : Self-checking bench for wifi_ahb_addr_decoder. Three decoders
//            with different wait/window settings share one stimulus stream;
//            each is compared cycle by cycle to a transfer-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wifi_ahb_addr_decoder;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam int K_REG = 0;
    localparam int K_MEM = 1;
    localparam int K_ERR = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        t_sel;
    logic [11:0] t_addr;
    logic [1:0]  t_trans;
    logic        t_write;
    logic [2:0]  t_size;
    logic        hready_drv [3];
`ifdef WIFI_DEC_STATS_EN
    logic        stat_clr;
`endif

    int checks   = 0;
    int failures = 0;

    // Transfer-level model state per decoder
    bit m_active [3];
    int m_kind   [3];
    bit m_wr     [3];
    int m_la     [3];
    int m_e      [3];
    int m_errs   [3];

    always #5 clk = ~clk;

    wifi_ahb_addr_decoder_if #(.ADDR_AHB(12)) bus0 ();
    wifi_ahb_addr_decoder_if #(.ADDR_AHB(12)) bus1 ();
    wifi_ahb_addr_decoder_if #(.ADDR_AHB(12)) bus2 ();

    assign bus0.HSEL = t_sel;  assign bus0.HADDR = t_addr;  assign bus0.HTRANS = t_trans;
    assign bus0.HWRITE = t_write;  assign bus0.HSIZE = t_size;  assign bus0.HREADY = hready_drv[0];
    assign bus1.HSEL = t_sel;  assign bus1.HADDR = t_addr;  assign bus1.HTRANS = t_trans;
    assign bus1.HWRITE = t_write;  assign bus1.HSIZE = t_size;  assign bus1.HREADY = hready_drv[1];
    assign bus2.HSEL = t_sel;  assign bus2.HADDR = t_addr;  assign bus2.HTRANS = t_trans;
    assign bus2.HWRITE = t_write;  assign bus2.HSIZE = t_size;  assign bus2.HREADY = hready_drv[2];

    logic wreg0, rreg0, wmem0, rmem0, wreg1, rreg1, wmem1, rmem1, wreg2, rreg2, wmem2, rmem2;
    logic [1:0] areg0, areg1, areg2;
    logic [9:0] amem0, amem1, amem2;
`ifdef WIFI_DEC_STATS_EN
    logic [7:0] ecnt0, ecnt1, ecnt2;
`endif

    wifi_ahb_addr_decoder #(.MEM_WAIT(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .ahb(bus0),
        .wren_reg(wreg0), .rden_reg(rreg0), .addr_reg(areg0),
        .wren_mem(wmem0), .rden_mem(rmem0), .addr_mem(amem0)
`ifdef WIFI_DEC_STATS_EN
        , .stat_clr(stat_clr), .err_count(ecnt0)
`endif
    );

    wifi_ahb_addr_decoder #(.MEM_WAIT(2)) dut1 (
        .HCLK(clk), .HRESETn(rst_n), .ahb(bus1),
        .wren_reg(wreg1), .rden_reg(rreg1), .addr_reg(areg1),
        .wren_mem(wmem1), .rden_mem(rmem1), .addr_mem(amem1)
`ifdef WIFI_DEC_STATS_EN
        , .stat_clr(stat_clr), .err_count(ecnt1)
`endif
    );

    wifi_ahb_addr_decoder #(.MEM_WAIT(3), .MEM_BASE('h20), .MEM_BYTES(512)) dut2 (
        .HCLK(clk), .HRESETn(rst_n), .ahb(bus2),
        .wren_reg(wreg2), .rden_reg(rreg2), .addr_reg(areg2),
        .wren_mem(wmem2), .rden_mem(rmem2), .addr_mem(amem2)
`ifdef WIFI_DEC_STATS_EN
        , .stat_clr(stat_clr), .err_count(ecnt2)
`endif
    );

    logic [17:0] obs0, obs1, obs2;
    assign obs0 = {bus0.HREADYOUT, bus0.HRESP, wreg0, rreg0, wmem0, rmem0, areg0, amem0};
    assign obs1 = {bus1.HREADYOUT, bus1.HRESP, wreg1, rreg1, wmem1, rmem1, areg1, amem1};
    assign obs2 = {bus2.HREADYOUT, bus2.HRESP, wreg2, rreg2, wmem2, rmem2, areg2, amem2};

    function automatic int mw(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic int mbase(input int k);
        return (k == 2) ? 'h20 : 'h10;
    endfunction

    function automatic int mbytes(input int k);
        return (k == 2) ? 512 : 1024;
    endfunction

    // Data-phase length in cycles of the transfer the model holds
    function automatic int xlen(input int k);
        if (m_kind[k] == K_REG) return 1;
        if (m_kind[k] == K_MEM) return 1 + mw(k);
        return 2;
    endfunction

    function automatic int classify(input int k, input int a, input int s, output int la);
        la = 0;
        if (s > 2) return K_ERR;
        if ((a % (1 << s)) != 0) return K_ERR;
        if (a < 16) begin
            la = a / 4;
            return K_REG;
        end
        if ((a >= mbase(k)) && (a < mbase(k) + mbytes(k))) begin
            la = a - mbase(k);
            return K_MEM;
        end
        return K_ERR;
    endfunction

    function automatic logic [17:0] exp_vec(input int k);
        bit act, ready, resp, strobe;
        int ar, am;
        act    = m_active[k];
        ready  = !act || (m_e[k] == xlen(k) - 1);
        resp   = act && (m_kind[k] == K_ERR);
        strobe = act && (m_e[k] == 0) && (m_kind[k] != K_ERR);
        ar     = (act && m_kind[k] == K_REG) ? m_la[k] : 0;
        am     = (act && m_kind[k] == K_MEM) ? m_la[k] : 0;
        return {ready, resp,
                strobe && m_kind[k] == K_REG &&  m_wr[k],
                strobe && m_kind[k] == K_REG && !m_wr[k],
                strobe && m_kind[k] == K_MEM &&  m_wr[k],
                strobe && m_kind[k] == K_MEM && !m_wr[k],
                2'(ar), 10'(am)};
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, o, e);
        end
    endtask

    task automatic check_dut(input int k, input logic [17:0] o);
        logic [17:0] e;
        e = exp_vec(k);
        chk("hreadyout", k, 32'(o[17]), 32'(e[17]));
        chk("hresp",     k, 32'(o[16]), 32'(e[16]));
        chk("wren_reg",  k, 32'(o[15]), 32'(e[15]));
        chk("rden_reg",  k, 32'(o[14]), 32'(e[14]));
        chk("wren_mem",  k, 32'(o[13]), 32'(e[13]));
        chk("rden_mem",  k, 32'(o[12]), 32'(e[12]));
        chk("addr_reg",  k, 32'(o[11:10]), 32'(e[11:10]));
        chk("addr_mem",  k, 32'(o[9:0]), 32'(e[9:0]));
    endtask

    task automatic check_all();
        check_dut(0, obs0);
        check_dut(1, obs1);
        check_dut(2, obs2);
`ifdef WIFI_DEC_STATS_EN
        chk("err_count", 0, 32'(ecnt0), m_errs[0]);
        chk("err_count", 1, 32'(ecnt1), m_errs[1]);
        chk("err_count", 2, 32'(ecnt2), m_errs[2]);
`endif
    endtask

    task automatic refresh_ready();
        logic [17:0] e;
        for (int k = 0; k < 3; k++) begin
            e = exp_vec(k);
            hready_drv[k] = e[17];
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_active[k] = 0;
            m_kind[k]   = K_REG;
            m_wr[k]     = 0;
            m_la[k]     = 0;
            m_e[k]      = 0;
            m_errs[k]   = 0;
        end
        refresh_ready();
    endtask

    // Advance every model by one clock edge using the inputs it sampled
    task automatic model_edge();
        bit acc;
        int la;
        for (int k = 0; k < 3; k++) begin
            acc = t_sel && hready_drv[k] && t_trans[1];
            if (m_active[k]) begin
                if (m_e[k] == xlen(k) - 1) m_active[k] = 0;
                else m_e[k]++;
            end
            if (acc) begin
                m_kind[k]   = classify(k, int'(t_addr), int'(t_size), la);
                m_la[k]     = la;
                m_wr[k]     = t_write;
                m_active[k] = 1;
                m_e[k]      = 0;
                if (m_kind[k] == K_ERR && m_errs[k] < 255) m_errs[k]++;
            end
`ifdef WIFI_DEC_STATS_EN
            if (stat_clr) m_errs[k] = 0;
`endif
        end
        refresh_ready();
    endtask

    task automatic step(input logic sel, input logic [11:0] addr, input logic [1:0] trans,
                        input logic wr, input logic [2:0] size);
        t_sel   = sel;
        t_addr  = addr;
        t_trans = trans;
        t_write = wr;
        t_size  = size;
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 12'h0, T_IDLE, 1'b0, 3'd2);
    endtask

    initial begin
        int a, sz;
        rst_n   = 1'b0;
        t_sel   = 1'b0;
        t_addr  = '0;
        t_trans = T_IDLE;
        t_write = 1'b0;
        t_size  = 3'd2;
`ifdef WIFI_DEC_STATS_EN
        stat_clr = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Register write to word 2
        step(1'b1, 12'h008, T_NONSEQ, 1'b1, 3'd2);
        chk("d_wr_reg_strobe", 1, 32'(wreg1), 1);
        chk("d_wr_reg_index", 1, 32'(areg1), 2);
        chk("d_wr_reg_ready", 1, 32'(bus1.HREADYOUT), 1);
        idle(1);
        chk("d_wr_reg_single", 1, 32'(wreg1), 0);

        // Memory read with two wait states
        step(1'b1, 12'h024, T_NONSEQ, 1'b0, 3'd2);
        chk("d_rd_mem_strobe", 1, 32'(rmem1), 1);
        chk("d_rd_mem_offset", 1, 32'(amem1), 'h14);
        chk("d_rd_mem_wait1", 1, 32'(bus1.HREADYOUT), 0);
        idle(1);
        chk("d_rd_mem_wait2", 1, 32'(bus1.HREADYOUT), 0);
        chk("d_rd_mem_single", 1, 32'(rmem1), 0);
        idle(1);
        chk("d_rd_mem_done", 1, 32'(bus1.HREADYOUT), 1);
        idle(2);

        // Out-of-range then misaligned word: two-cycle ERROR each
        step(1'b1, 12'h410, T_NONSEQ, 1'b0, 3'd2);
        chk("d_err_range_resp", 1, 32'(bus1.HRESP), 1);
        chk("d_err_range_ready", 1, 32'(bus1.HREADYOUT), 0);
        chk("d_err_range_nostrobe", 1, 32'(rmem1 | rreg1), 0);
        idle(1);
        chk("d_err_range_resp2", 1, 32'(bus1.HRESP), 1);
        chk("d_err_range_ready2", 1, 32'(bus1.HREADYOUT), 1);
        step(1'b1, 12'h002, T_NONSEQ, 1'b0, 3'd2);
        chk("d_err_align_resp", 1, 32'(bus1.HRESP), 1);
        chk("d_err_align_ready", 1, 32'(bus1.HREADYOUT), 0);
        idle(1);
        chk("d_err_align_ready2", 1, 32'(bus1.HREADYOUT), 1);
`ifdef WIFI_DEC_STATS_EN
        chk("d_err_count", 1, 32'(ecnt1), 2);
`endif
        idle(1);

        // Back-to-back register write then memory read
        step(1'b1, 12'h004, T_NONSEQ, 1'b1, 3'd2);
        chk("d_b2b_wr_reg", 0, 32'(wreg0), 1);
        chk("d_b2b_ready1", 0, 32'(bus0.HREADYOUT), 1);
        step(1'b1, 12'h010, T_NONSEQ, 1'b0, 3'd2);
        chk("d_b2b_rd_mem", 0, 32'(rmem0), 1);
        chk("d_b2b_addr_mem", 0, 32'(amem0), 0);
        chk("d_b2b_ready2", 0, 32'(bus0.HREADYOUT), 1);
        chk("d_gap_err", 2, 32'(bus2.HRESP), 1);
        idle(4);

        // Non-transfers: deselected, BUSY, IDLE
        step(1'b0, 12'h008, T_NONSEQ, 1'b1, 3'd2);
        chk("d_hsel_low", 0, 32'(wreg0), 0);
        step(1'b1, 12'h008, T_BUSY, 1'b1, 3'd2);
        chk("d_busy", 0, 32'(wreg0), 0);
        step(1'b1, 12'h410, T_IDLE, 1'b0, 3'd2);
        chk("d_idle_resp", 0, 32'(bus0.HRESP), 0);

        // Asynchronous reset in the middle of a 3-wait-state read
        step(1'b1, 12'h030, T_NONSEQ, 1'b0, 3'd2);
        idle(1);
        chk("d_rst_pre_wait", 2, 32'(bus2.HREADYOUT), 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("d_rst_ready", 2, 32'(bus2.HREADYOUT), 1);
        chk("d_rst_addr_mem", 2, 32'(amem2), 0);
        #2;
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       a = int'($urandom_range(0, 15));
                1:       a = int'($urandom_range('h10, 'h40f));
                2:       a = int'($urandom_range('h400, 'h43f));
                default: a = int'($urandom_range(0, 4095));
            endcase
            sz = ($urandom_range(0, 11) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
            if (sz <= 2 && $urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
`ifdef WIFI_DEC_STATS_EN
            stat_clr = ($urandom_range(0, 39) == 0);
`endif
            step($urandom_range(0, 7) != 0, 12'(a), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 3'(sz));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
